mdclcg_core: RTL
================

MDCLCG_CORE -- requirements
Module: mdclcg_core

Interface
REQ-001 Parameter: W, 16, state/word width; the only value supported is 16.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 seed_load  in  1  load seeds this cycle; has priority over enable.
REQ-005 seed_x1, seed_x2, seed_y1, seed_y2  in  16 each  seed values for the four LCGs.
REQ-006 enable  in  1  1 = keep generating; 0 = pause.
REQ-007 busy  out  1  high while in state RUN.
REQ-008 bit_out  out  1  generated bit; qualified by bit_valid.
REQ-009 bit_valid  out  1  one-cycle pulse per accepted bit.
REQ-010 word_out  out  16  last completed 16-bit word; qualified by word_valid.
REQ-011 word_valid  out  1  one-cycle pulse per completed word.

Function
REQ-012 The block shall hold four 16-bit LCG registers, X1, X2, Y1 and Y2.
REQ-013 Each step shall compute next = ((s << K) + s + B) mod 2^16, i.e. a = 2^K+1, as one three-operand addition truncated to 16 bits.
REQ-014 Constants (K, B): X1 (5,1), X2 (3,3), Y1 (7,5), Y2 (4,7).
REQ-015 FSM states: IDLE (no stepping) and RUN (all four LCGs step every cycle).
REQ-016 IDLE->RUN on enable=1 with seed_load=0; the first step occurs on the edge after RUN is entered.
REQ-017 RUN->IDLE on enable=0; no step occurs on that edge.
REQ-018 seed_load=1 in any state, on the next edge: loads all four seeds, clears the bit counter and accumulator, sets state IDLE, and forces bit_valid and word_valid to 0.
REQ-019 On each step: Bb = (X1next > X2next) and Cb = (Y1next > Y2next), both unsigned strict compares.
REQ-020 bit_out and bit_valid shall be registered on the same edge as the state update: bit_out <= Bb, bit_valid <= Cb, giving one-cycle latency from the step decision.
REQ-021 When Cb=0: bit_valid=0 and bit_out holds its previous value; no bit is accepted.
REQ-022 Each accepted bit shall shift into the accumulator LSB (acc <= {acc[14:0], Bb}) and increment a 4-bit counter.
REQ-023 When the counter wraps 15->0: word_out <= {acc[14:0], Bb} and word_valid pulses for one cycle; the first accepted bit becomes the word MSB.
REQ-024 word_out shall hold its value between pulses; bit_valid and word_valid may pulse in the same cycle.
REQ-025 The block shall have no backpressure; a consumer that is not ready loses the bit.

Reset
REQ-026 On rst: X1=16'h1234, X2=16'hABCD, Y1=16'h0F0F, Y2=16'h3C3C.
REQ-027 On rst: state IDLE; counter and accumulator 0; busy, bit_out, bit_valid, word_valid 0; word_out 16'h0000.
REQ-028 Reset asserted mid-RUN shall abort immediately (asynchronously); enable must be reasserted after release to resume.

Structure
REQ-029 A shared package shall hold W, the K/B constant pairs, the reset seeds, and the state enum.
REQ-030 Sub-module lcg_stage (16-bit state in, K and B as parameters, 16-bit next out) shall be instantiated four times; FSM, comparators and accumulator live in mdclcg_core.

Verification
REQ-031 Reset, then enable=1 -> first step gives X1=0x58B5, X2=0x0A38, Y1=0x9694, Y2=0x0003; bit_valid=1, bit_out=1.
REQ-032 seed_load with all seeds 0, then enable -> first step gives X1=1, X2=3, Y1=5, Y2=7; bit_valid=0.
REQ-033 Run until 16 bit_valid pulses -> word_valid pulses exactly once, together with the 16th bit; word_out equals the 16 bits in arrival order, MSB first.
REQ-034 seed_load and enable both high in RUN -> seeds loaded, state IDLE, busy=0 next cycle, no bit_valid pulse.
REQ-035 Assert rst mid-RUN, asynchronously between edges -> outputs 0 and registers at reset seeds immediately; after release stays IDLE until enable.
REQ-036 Drop enable for 3 cycles in RUN -> registers frozen, no pulses; resumes from the same state.

Source files
------------

// File: rtl/mdclcg_pkg.sv
// mdclcg_pkg: shared width, LCG multiplier/increment pairs, reset seeds and FSM states.
package mdclcg_pkg;
  localparam int W = 16;
  localparam int X1_K = 5;
  localparam int X2_K = 3;
  localparam int Y1_K = 7;
  localparam int Y2_K = 4;
  localparam logic [W-1:0] X1_B = 16'd1;
  localparam logic [W-1:0] X2_B = 16'd3;
  localparam logic [W-1:0] Y1_B = 16'd5;
  localparam logic [W-1:0] Y2_B = 16'd7;
  localparam logic [W-1:0] X1_RST = 16'h1234;
  localparam logic [W-1:0] X2_RST = 16'hABCD;
  localparam logic [W-1:0] Y1_RST = 16'h0F0F;
  localparam logic [W-1:0] Y2_RST = 16'h3C3C;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/lcg_stage.sv
// lcg_stage: one LCG step, next = s*(2^K+1) + B mod 2^W, done as a shift-add.
module lcg_stage
  import mdclcg_pkg::*;
#(
  parameter int K = 1,
  parameter logic [W-1:0] B = '0
) (
  input  logic [W-1:0] i_s,
  output logic [W-1:0] o_next
);
  assign o_next = (i_s << K) + i_s + B;
endmodule

// File: rtl/mdclcg_core.sv
// mdclcg_core: four shift-add LCGs; X pair compare yields the bit, Y pair compare qualifies it.
module mdclcg_core #(
  parameter int W = mdclcg_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         seed_load,
  input  logic [W-1:0] seed_x1,
  input  logic [W-1:0] seed_x2,
  input  logic [W-1:0] seed_y1,
  input  logic [W-1:0] seed_y2,
  input  logic         enable,
  output logic         busy,
  output logic         bit_out,
  output logic         bit_valid,
  output logic [W-1:0] word_out,
  output logic         word_valid
);
  import mdclcg_pkg::*;
  state_t r_state, w_next;
  logic [W-1:0] r_x1, r_x2, r_y1, r_y2;
  logic [W-1:0] w_x1, w_x2, w_y1, w_y2;
  logic [W-1:0] r_acc;
  logic [3:0] r_cnt;
  logic w_step, w_bb, w_cb, w_acc;
  lcg_stage #(.K(X1_K), .B(X1_B)) u_x1 (.i_s(r_x1), .o_next(w_x1));
  lcg_stage #(.K(X2_K), .B(X2_B)) u_x2 (.i_s(r_x2), .o_next(w_x2));
  lcg_stage #(.K(Y1_K), .B(Y1_B)) u_y1 (.i_s(r_y1), .o_next(w_y1));
  lcg_stage #(.K(Y2_K), .B(Y2_B)) u_y2 (.i_s(r_y2), .o_next(w_y2));
  assign w_step = (r_state == RUN) && enable && !seed_load;
  assign w_bb = w_x1 > w_x2;
  assign w_cb = w_y1 > w_y2;
  assign w_acc = w_step && w_cb;
  assign busy = r_state == RUN;
  always_comb begin
    w_next = (enable && !seed_load) ? RUN : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_x1 <= X1_RST;
      r_x2 <= X2_RST;
      r_y1 <= Y1_RST;
      r_y2 <= Y2_RST;
      r_acc <= '0;
      r_cnt <= '0;
      bit_out <= 1'b0;
      bit_valid <= 1'b0;
      word_out <= '0;
      word_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (seed_load) begin
        r_x1 <= seed_x1;
        r_x2 <= seed_x2;
        r_y1 <= seed_y1;
        r_y2 <= seed_y2;
        r_acc <= '0;
        r_cnt <= '0;
        bit_valid <= 1'b0;
        word_valid <= 1'b0;
      end else begin
        bit_valid <= w_acc;
        word_valid <= w_acc && (r_cnt == 4'hF);
        if (w_step) begin
          r_x1 <= w_x1;
          r_x2 <= w_x2;
          r_y1 <= w_y1;
          r_y2 <= w_y2;
        end
        if (w_acc) begin
          bit_out <= w_bb;
          r_acc <= {r_acc[W-2:0], w_bb};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'hF) word_out <= {r_acc[W-2:0], w_bb};
        end
      end
    end
  end
endmodule
